// File: rtl/alu_defs_pkg.sv
// Shared execute-stage decode definitions: 6-bit funct codes and the
// multiplier's state encoding, so the ALU and multu_hilo decode identically.
package alu_defs_pkg;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the multiplier: conditionally add the multiplicand
// into the upper half, then shift the whole product right by one keeping the carry.
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic [2*WIDTH-1:0] p_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, p_i[2*WIDTH-1:WIDTH]} + (p_i[0] ? {1'b0, mcand_i} : '0);
        p_o = {sum, p_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/multu_hilo.sv
// Multi-cycle shift-add multiplier with HI/LO result registers and MFHI/MFLO readout.
// Define MULTU_SIGNED_EN to also accept signed MULT (sign-magnitude around the same datapath).
module multu_hilo
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    localparam int CW = $clog2(WIDTH);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] result;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               sign_q, sign_d;

    logic               start;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               op_sign;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .p_i     (prod_q),
        .mcand_i (mcand_q),
        .p_o     (prod_step)
    );

    // Operand preparation: signed MULT runs on magnitudes and fixes the sign at the end.
    always_comb begin
`ifdef MULTU_SIGNED_EN
        logic is_mult;
        is_mult = (Signal == FUNCT_MULT);
        start   = valid && (Signal == FUNCT_MULTU || is_mult);
        op_a    = (is_mult && dataA[WIDTH-1]) ? -dataA : dataA;
        op_b    = (is_mult && dataB[WIDTH-1]) ? -dataB : dataB;
        op_sign = is_mult && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
        result  = sign_q ? -prod_q : prod_q;
`else
        start   = valid && (Signal == FUNCT_MULTU);
        op_a    = dataA;
        op_b    = dataB;
        op_sign = 1'b0;
        result  = prod_q;
`endif
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sign_d  = sign_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    prod_d  = {{WIDTH{1'b0}}, op_b};
                    count_d = '0;
                    sign_d  = op_sign;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                prod_d  = prod_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                {hi_d, lo_d} = result;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sign_q  <= sign_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    always_comb begin
        dataOut = '0;
        case (Signal)
            FUNCT_MFHI: dataOut = hi_q;
            FUNCT_MFLO: dataOut = lo_q;
            default:    dataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: directed corner cases plus randomized
// multiplies compared against a plain-arithmetic product model.
module tb_multu_hilo;
    import alu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] dataA, dataB;
    logic [5:0]  Signal;
    logic        busy, done;
    logic [31:0] dataOut;

    int n_checks = 0;
    int n_errors = 0;

    multu_hilo #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .busy    (busy),
        .done    (done),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (f == FUNCT_MULT) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called at a falling edge; reads a register through the combinational output.
    task automatic rd(input logic [5:0] f, input logic [31:0] exp, input string tag);
        valid  = 1'b1;
        Signal = f;
        #1;
        check(tag, dataOut, exp);
    endtask

    // Presents a request for one cycle; returns at the falling edge of the cycle after it.
    task automatic start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid  = 1'b1;
        Signal = f;
        dataA  = a;
        dataB  = b;
        @(negedge clk);
        valid  = 1'b0;
        Signal = FUNCT_ADD;
    endtask

    // lat0 is how many cycles after acceptance we are now; returns in the done cycle.
    task automatic wait_done(input int lat0, input string tag);
        int lat = lat0;
        int bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        check({tag, " done latency"}, 64'(lat), 64'd33);
        check({tag, " busy cycles"}, 64'(bc), 64'(33 - lat0));
        check({tag, " busy low at done"}, 64'(busy), 64'd0);
    endtask

    task automatic read_back(input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input string tag);
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 64'd0);
        rd(FUNCT_MFHI, exp_hi, {tag, " HI"});
        rd(FUNCT_MFLO, exp_lo, {tag, " LO"});
    endtask

    task automatic run_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input string tag);
        start(f, a, b);
        wait_done(1, tag);
        read_back(exp_hi, exp_lo, tag);
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] a, b;
        logic [5:0]  f;

        reset  = 1'b0;
        valid  = 1'b0;
        Signal = FUNCT_ADD;
        dataA  = '0;
        dataB  = '0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rd(FUNCT_MFHI, 32'h0, "reset HI");
        rd(FUNCT_MFLO, 32'h0, "reset LO");
        @(negedge clk);
        reset = 1'b1;

        run_mul(FUNCT_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, "7x6");
        run_mul(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "max");

        // A request during the done cycle is ignored, then taken in the following idle cycle.
        start(FUNCT_MULTU, 32'd7, 32'd6);
        wait_done(1, "pre-done");
        valid  = 1'b1;
        Signal = FUNCT_MULTU;
        dataA  = 32'd3;
        dataB  = 32'd5;
        #1;
        check("multu funct dataOut", 64'(dataOut), 64'd0);
        @(negedge clk);
        check("request in done ignored", 64'(busy), 64'd0);
        @(negedge clk);
        check("request in idle accepted", 64'(busy), 64'd1);
        valid  = 1'b0;
        Signal = FUNCT_ADD;
        wait_done(1, "3x5");
        read_back(32'd0, 32'd15, "3x5");

        // Old HI readable during busy; second request during busy is dropped.
        run_mul(FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0, "hi1");
        start(FUNCT_MULTU, 32'hFFFFFFFF, 32'd3);
        for (int i = 0; i < 5; i++) begin
            rd(FUNCT_MFHI, 32'd1, "old HI while busy");
            check("busy during run", 64'(busy), 64'd1);
            @(negedge clk);
        end
        valid  = 1'b1;
        Signal = FUNCT_MULTU;
        dataA  = 32'd9;
        dataB  = 32'd9;
        @(negedge clk);
        valid  = 1'b0;
        Signal = FUNCT_ADD;
        wait_done(7, "busy-ignore");
        read_back(32'd2, 32'hFFFFFFFD, "busy-ignore");

        // Asynchronous reset in the middle of a run.
        start(FUNCT_MULTU, 32'hDEADBEEF, 32'h00012345);
        repeat (9) @(negedge clk);
        check("busy before abort", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        rd(FUNCT_MFLO, 32'h0, "abort LO");
        rd(FUNCT_MFHI, 32'h0, "abort HI");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle after abort", 64'(busy), 64'd0);
        rd(FUNCT_MFLO, 32'h0, "LO after abort");

        // Zero product followed by a non-multiply funct.
        run_mul(FUNCT_MULTU, 32'd0, 32'h12345678, 32'd0, 32'd0, "zero");
        valid  = 1'b1;
        Signal = FUNCT_ADD;
        dataA  = 32'd5;
        dataB  = 32'd6;
        #1;
        check("ADD dataOut", 64'(dataOut), 64'd0);
        check("ADD busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("ADD no start", 64'(busy), 64'd0);

`ifdef MULTU_SIGNED_EN
        run_mul(FUNCT_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3x5");
`else
        valid  = 1'b1;
        Signal = FUNCT_MULT;
        dataA  = 32'hFFFFFFFD;
        dataB  = 32'd5;
        @(negedge clk);
        valid  = 1'b0;
        Signal = FUNCT_ADD;
        check("MULT ignored", 64'(busy), 64'd0);
        @(negedge clk);
        check("MULT still idle", 64'(busy), 64'd0);
        rd(FUNCT_MFHI, 32'd0, "MULT HI unchanged");
        rd(FUNCT_MFLO, 32'd0, "MULT LO unchanged");
`endif

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: a = 32'hFFFFFFFF;
                1: b = 32'h80000000;
                2: a = $urandom_range(0, 15);
                default: ;
            endcase
            f = FUNCT_MULTU;
`ifdef MULTU_SIGNED_EN
            if ($urandom_range(0, 1) == 1) f = FUNCT_MULT;
`endif
            p = ref_prod(f, a, b);
            run_mul(f, a, b, p[63:32], p[31:0], "random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
